jedro_1_ifu_prefetch: RTL and testbench

Parametrised prefetching instruction fetch unit for the jedro_1 core. It issues sequential fetches to a fixed-latency, non-stallable instruction memory and buffers the returned words in a FIFO. It presents them to the decoder over a valid/ready handshake, and flushes all buffered and in-flight fetches on a jump. It sits between the instruction ROM/SPRAM port and the decoder.

---
 rtl/jedro_1_ifu_prefetch_if.sv | 40 ++++
 rtl/jedro_1_ifu_prefetch.sv | 131 +++++++++++++
 tb/tb_jedro_1_ifu_prefetch.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_ifu_prefetch_if.sv
// Bundle of fetch-side signals for the jedro_1 prefetching IFU: the jump
// redirect from the core, the decoder handshake and the instruction memory port.
// master = the prefetch unit, slave = its environment (core, decoder, memory).
interface jedro_1_ifu_prefetch_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  jmp_instr_i;
    logic [DATA_WIDTH-1:0] jmp_address_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] instr_addr_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic                  mem_req_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        input  jmp_instr_i,
        input  jmp_address_i,
        input  instr_ready_i,
        input  mem_rdata_i,
        output instr_o,
        output instr_addr_o,
        output instr_valid_o,
        output mem_req_o,
        output mem_addr_o
    );

    modport slave (
        output jmp_instr_i,
        output jmp_address_i,
        output instr_ready_i,
        output mem_rdata_i,
        input  instr_o,
        input  instr_addr_o,
        input  instr_valid_o,
        input  mem_req_o,
        input  mem_addr_o
    );
endinterface

// File: rtl/jedro_1_ifu_prefetch.sv
// Prefetching instruction fetch unit for jedro_1. Issues sequential fetches to a
// fixed-latency, non-stallable memory, tracks each request with an in-flight tag
// and buffers returned words in a first-word fall-through FIFO. A request is only
// issued when a FIFO slot is guaranteed for its data (buffered + in-flight < depth),
// so the memory never needs to stall. A jump flushes the FIFO and kills all tags.
// FIFO_DEPTH must be a power of two >= 2; MEM_LATENCY must be 1..4.
module jedro_1_ifu_prefetch #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR   = '0,
    parameter int unsigned           FIFO_DEPTH  = 4,
    parameter int unsigned           MEM_LATENCY = 1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    jedro_1_ifu_prefetch_if.master bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SumW = CntW + 1;

    logic [DATA_WIDTH-1:0]  pc_q, pc_d;
    logic [MEM_LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [DATA_WIDTH-1:0]  tag_addr_q [MEM_LATENCY];
    logic [DATA_WIDTH-1:0]  tag_addr_d [MEM_LATENCY];
    logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [CntW-1:0]        inflight;
    logic                   jmp, issue, push, pop, fifo_valid;
    logic                   unused_jmp_lsb;

    assign jmp            = bus.jmp_instr_i;
    // Jump targets are word aligned; the low bits are deliberately dropped.
    assign unused_jmp_lsb = ^bus.jmp_address_i[1:0];

    // Count outstanding requests in the in-flight pipe.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CntW'(tag_valid_q[i]);
        end
    end

    // Credit check uses start-of-cycle counts; a pop frees its slot next cycle.
    always_comb begin
        fifo_valid = (count_q != '0);
        pop        = fifo_valid && bus.instr_ready_i;
        push       = tag_valid_q[MEM_LATENCY-1] && !jmp;
        issue      = !rst_i && !jmp &&
                     (({1'b0, count_q} + {1'b0, inflight}) < SumW'(FIFO_DEPTH));
    end

    // Next fetch PC and in-flight tag pipe; a jump kills every tag.
    always_comb begin
        pc_d          = pc_q;
        tag_valid_d   = '0;
        tag_valid_d[0] = issue;
        tag_addr_d[0] = pc_q;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_addr_d[i]  = tag_addr_q[i-1];
        end
        if (jmp) begin
            tag_valid_d = '0;
            pc_d        = {bus.jmp_address_i[DATA_WIDTH-1:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end
    end

    // FIFO pointer and occupancy update; a jump empties the buffer.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (jmp) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrW'(1);
            if (pop)  rptr_d = rptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= BOOT_ADDR;
            tag_valid_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            tag_valid_q <= tag_valid_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Datapath storage; contents are qualified by the valid bits so need no reset.
    always_ff @(posedge clk_i) begin
        tag_addr_q <= tag_addr_d;
        if (push) begin
            fifo_data_q[wptr_q] <= bus.mem_rdata_i;
            fifo_addr_q[wptr_q] <= tag_addr_q[MEM_LATENCY-1];
        end
    end

    // Outputs; head fields read as zero while the FIFO is empty.
    always_comb begin
        bus.mem_req_o     = issue;
        bus.mem_addr_o    = pc_q;
        bus.instr_valid_o = fifo_valid;
        bus.instr_o       = fifo_valid ? fifo_data_q[rptr_q] : '0;
        bus.instr_addr_o  = fifo_valid ? fifo_addr_q[rptr_q] : '0;
    end

    // The credit rule must make overflow unreachable.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     !(push && (count_q == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_jedro_1_ifu_prefetch.sv
// Directed bench for jedro_1_ifu_prefetch: a latency-1/depth-4 instance for the
// directed scenarios and a latency-3/depth-8 instance for the random-ready run.
// Memory model returns addr ^ 32'hA5A5_0000 exactly MEM_LATENCY cycles later.
module tb_jedro_1_ifu_prefetch;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jedro_1_ifu_prefetch_if #(.DATA_WIDTH(32)) bus0 ();
    jedro_1_ifu_prefetch_if #(.DATA_WIDTH(32)) bus1 ();

    jedro_1_ifu_prefetch #(
        .DATA_WIDTH(32), .BOOT_ADDR(32'h0), .FIFO_DEPTH(4), .MEM_LATENCY(1)
    ) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.master));

    jedro_1_ifu_prefetch #(
        .DATA_WIDTH(32), .BOOT_ADDR(32'h0), .FIFO_DEPTH(8), .MEM_LATENCY(3)
    ) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.master));

    // Fixed-latency memory models
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];
    always @(posedge clk) begin
        pipe0    <= bus0.mem_addr_o;
        pipe1[0] <= bus1.mem_addr_o;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign bus0.mem_rdata_i = pipe0 ^ K;
    assign bus1.mem_rdata_i = pipe1[2] ^ K;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset edge; returns in cycle 0 (first cycle with rst low), before sampling.
    task automatic apply_reset();
        rst = 1'b1;
        bus0.jmp_instr_i = 1'b0;
        bus1.jmp_instr_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus0.instr_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %0h want 0", bus0.instr_valid_o); end
        checks++; if (bus0.instr_o !== 32'h0) begin errors++;
            $display("FAIL reset_instr got %h want 0", bus0.instr_o); end
        checks++; if (bus0.instr_addr_o !== 32'h0) begin errors++;
            $display("FAIL reset_instr_addr got %h want 0", bus0.instr_addr_o); end
        checks++; if (bus0.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL reset_req got %0h want 0", bus0.mem_req_o); end
        checks++; if (bus0.mem_addr_o !== 32'h0) begin errors++;
            $display("FAIL reset_mem_addr got %h want 0", bus0.mem_addr_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b1 || bus0.mem_addr_o !== 32'h0) begin errors++;
            $display("FAIL reset_first_req got %0h/%h want 1/0",
                     bus0.mem_req_o, bus0.mem_addr_o); end
    endtask

    task automatic test_stream();
        bus0.instr_ready_i = 1'b1;
        apply_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            checks++; if (bus0.mem_req_o !== 1'b1 || bus0.mem_addr_o !== 32'(cyc * 4)) begin
                errors++;
                $display("FAIL stream_req c%0d got %0h/%h want 1/%h", cyc,
                         bus0.mem_req_o, bus0.mem_addr_o, 32'(cyc * 4)); end
            if (cyc < 2) begin
                checks++; if (bus0.instr_valid_o !== 1'b0) begin errors++;
                    $display("FAIL stream_early_valid c%0d got %0h want 0", cyc,
                             bus0.instr_valid_o); end
            end else begin
                checks++;
                if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'((cyc - 2) * 4) ||
                    bus0.instr_o !== (32'((cyc - 2) * 4) ^ K)) begin
                    errors++;
                    $display("FAIL stream_data c%0d got %0h/%h/%h want 1/%h/%h", cyc,
                             bus0.instr_valid_o, bus0.instr_addr_o, bus0.instr_o,
                             32'((cyc - 2) * 4), 32'((cyc - 2) * 4) ^ K); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus0.instr_ready_i = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            checks++; if (bus0.mem_req_o !== (cyc <= 3)) begin errors++;
                $display("FAIL bp_req c%0d got %0h want %0h", cyc, bus0.mem_req_o, cyc <= 3); end
            if (cyc >= 2) begin
                checks++;
                if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'h0) begin errors++;
                    $display("FAIL bp_head c%0d got %0h/%h want 1/0", cyc,
                             bus0.instr_valid_o, bus0.instr_addr_o); end
            end
            tick();
        end
        bus0.instr_ready_i = 1'b1;
        for (int cyc = 12; cyc < 18; cyc++) begin
            #1;
            checks++;
            if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'((cyc - 12) * 4) ||
                bus0.instr_o !== (32'((cyc - 12) * 4) ^ K)) begin errors++;
                $display("FAIL bp_drain c%0d got %0h/%h/%h want 1/%h", cyc, bus0.instr_valid_o,
                         bus0.instr_addr_o, bus0.instr_o, 32'((cyc - 12) * 4)); end
            if (cyc == 12) begin
                checks++; if (bus0.mem_req_o !== 1'b0) begin errors++;
                    $display("FAIL bp_pop_credit got %0h want 0", bus0.mem_req_o); end
            end
            if (cyc == 13) begin
                checks++; if (bus0.mem_req_o !== 1'b1 || bus0.mem_addr_o !== 32'h10) begin
                    errors++;
                    $display("FAIL bp_resume got %0h/%h want 1/10", bus0.mem_req_o,
                             bus0.mem_addr_o); end
            end
            tick();
        end
    endtask

    task automatic test_jump();
        bus0.instr_ready_i = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 4; cyc++) tick();
        // Cycle 4: three buffered, 0xC in flight and returning now
        bus0.jmp_instr_i   = 1'b1;
        bus0.jmp_address_i = 32'h0000_0103;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b0 || bus0.instr_valid_o !== 1'b1) begin errors++;
            $display("FAIL jmp_cycle got %0h/%0h want 0/1", bus0.mem_req_o,
                     bus0.instr_valid_o); end
        tick();
        bus0.jmp_instr_i = 1'b0;
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b0) begin errors++;
            $display("FAIL jmp_flush got %0h want 0", bus0.instr_valid_o); end
        checks++; if (bus0.mem_req_o !== 1'b1 || bus0.mem_addr_o !== 32'h100) begin errors++;
            $display("FAIL jmp_target_req got %0h/%h want 1/100", bus0.mem_req_o,
                     bus0.mem_addr_o); end
        tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b0 || bus0.mem_addr_o !== 32'h104) begin
            errors++;
            $display("FAIL jmp_gap got %0h/%h want 0/104", bus0.instr_valid_o,
                     bus0.mem_addr_o); end
        tick();
        #1;
        checks++;
        if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'h100 ||
            bus0.instr_o !== (32'h100 ^ K)) begin errors++;
            $display("FAIL jmp_first got %0h/%h/%h want 1/100/%h", bus0.instr_valid_o,
                     bus0.instr_addr_o, bus0.instr_o, 32'h100 ^ K); end
        bus0.instr_ready_i = 1'b1;
        tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'h104) begin
            errors++;
            $display("FAIL jmp_second got %0h/%h want 1/104", bus0.instr_valid_o,
                     bus0.instr_addr_o); end
    endtask

    task automatic test_wrap();
        bus0.instr_ready_i = 1'b1;
        apply_reset();
        bus0.jmp_instr_i   = 1'b1;
        bus0.jmp_address_i = 32'hFFFF_FFFC;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL wrap_jmp_req got %0h want 0", bus0.mem_req_o); end
        tick();
        bus0.jmp_instr_i = 1'b0;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b1 || bus0.mem_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req got %0h/%h want 1/fffffffc", bus0.mem_req_o,
                     bus0.mem_addr_o); end
        tick();
        #1;
        checks++; if (bus0.mem_addr_o !== 32'h0) begin errors++;
            $display("FAIL wrap_pc got %h want 0", bus0.mem_addr_o); end
        tick();
        #1;
        checks++;
        if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'hFFFF_FFFC ||
            bus0.instr_o !== 32'h5A5A_FFFC) begin errors++;
            $display("FAIL wrap_top got %0h/%h/%h want 1/fffffffc/5a5afffc",
                     bus0.instr_valid_o, bus0.instr_addr_o, bus0.instr_o); end
        tick();
        #1;
        checks++;
        if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'h0 ||
            bus0.instr_o !== 32'hA5A5_0000) begin errors++;
            $display("FAIL wrap_zero got %0h/%h/%h want 1/0/a5a50000",
                     bus0.instr_valid_o, bus0.instr_addr_o, bus0.instr_o); end
    endtask

    task automatic test_back_to_back();
        bus0.instr_ready_i = 1'b1;
        apply_reset();
        for (int cyc = 0; cyc < 3; cyc++) tick();
        bus0.jmp_instr_i   = 1'b1;
        bus0.jmp_address_i = 32'h200;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL b2b_first_req got %0h want 0", bus0.mem_req_o); end
        tick();
        bus0.jmp_address_i = 32'h300;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b0 || bus0.instr_valid_o !== 1'b0) begin errors++;
            $display("FAIL b2b_second got %0h/%0h want 0/0", bus0.mem_req_o,
                     bus0.instr_valid_o); end
        tick();
        bus0.jmp_instr_i = 1'b0;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b1 || bus0.mem_addr_o !== 32'h300 ||
                      bus0.instr_valid_o !== 1'b0) begin errors++;
            $display("FAIL b2b_req got %0h/%h/%0h want 1/300/0", bus0.mem_req_o,
                     bus0.mem_addr_o, bus0.instr_valid_o); end
        tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b0) begin errors++;
            $display("FAIL b2b_gap got %0h want 0", bus0.instr_valid_o); end
        tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'h300) begin
            errors++;
            $display("FAIL b2b_first got %0h/%h want 1/300", bus0.instr_valid_o,
                     bus0.instr_addr_o); end
    endtask

    task automatic test_reset_midstream();
        bus0.instr_ready_i = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 6; cyc++) tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b1 || bus0.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL mid_full got %0h/%0h want 1/0", bus0.instr_valid_o,
                     bus0.mem_req_o); end
        rst = 1'b1;
        #1;
        checks++; if (bus0.mem_req_o !== 1'b0) begin errors++;
            $display("FAIL mid_rst_req got %0h want 0", bus0.mem_req_o); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b0 || bus0.mem_req_o !== 1'b1 ||
                      bus0.mem_addr_o !== 32'h0) begin errors++;
            $display("FAIL mid_after got %0h/%0h/%h want 0/1/0", bus0.instr_valid_o,
                     bus0.mem_req_o, bus0.mem_addr_o); end
        bus0.instr_ready_i = 1'b1;
        tick();
        #1;
        checks++; if (bus0.instr_valid_o !== 1'b0) begin errors++;
            $display("FAIL mid_stale got %0h want 0", bus0.instr_valid_o); end
        for (int cyc = 2; cyc < 4; cyc++) begin
            tick();
            #1;
            checks++;
            if (bus0.instr_valid_o !== 1'b1 || bus0.instr_addr_o !== 32'((cyc - 2) * 4) ||
                bus0.instr_o !== (32'((cyc - 2) * 4) ^ K)) begin errors++;
                $display("FAIL mid_restart c%0d got %0h/%h/%h want 1/%h", cyc,
                         bus0.instr_valid_o, bus0.instr_addr_o, bus0.instr_o,
                         32'((cyc - 2) * 4)); end
        end
    endtask

    task automatic test_random_latency3();
        logic [31:0] exp_addr;
        int          delivered;
        exp_addr  = 32'h0;
        delivered = 0;
        bus1.instr_ready_i = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus1.instr_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 3) begin
                checks++; if (bus1.instr_valid_o !== 1'b0) begin errors++;
                    $display("FAIL l3_early got %0h want 0", bus1.instr_valid_o); end
            end
            if (cyc == 4) begin
                checks++; if (bus1.instr_valid_o !== 1'b1) begin errors++;
                    $display("FAIL l3_first got %0h want 1", bus1.instr_valid_o); end
            end
            if (bus1.instr_valid_o === 1'b1 && bus1.instr_ready_i === 1'b1) begin
                checks++;
                if (bus1.instr_addr_o !== exp_addr || bus1.instr_o !== (exp_addr ^ K)) begin
                    errors++;
                    $display("FAIL l3_seq c%0d got %h/%h want %h/%h", cyc, bus1.instr_addr_o,
                             bus1.instr_o, exp_addr, exp_addr ^ K); end
                exp_addr  = exp_addr + 32'h4;
                delivered++;
            end
            tick();
        end
        checks++; if (delivered < 60) begin errors++;
            $display("FAIL l3_throughput got %0d want >= 60", delivered); end
    endtask

    initial begin
        bus0.jmp_instr_i   = 1'b0;
        bus0.jmp_address_i = 32'h0;
        bus0.instr_ready_i = 1'b0;
        bus1.jmp_instr_i   = 1'b0;
        bus1.jmp_address_i = 32'h0;
        bus1.instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
        test_random_latency3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
